// File: rtl/dmm_multi_port_manager_if.sv
// dmm_multi_port_manager_if
//   Bundles the core-side DMM request ports and the allocator API port of
//   dmm_multi_port_manager.
//   slave  : view taken by the manager (client requests and allocator
//            responses in; completions and allocator commands out)
//   master : view taken by the environment (cores plus allocator)
//   Per-channel 32-bit fields are packed, channel k at [32k+31:32k].
interface dmm_multi_port_manager_if #(
   parameter int NUM_CH = 2
);
   logic                  stall_i;
   logic [NUM_CH-1:0]     alloc_req_i;
   logic [NUM_CH-1:0]     realloc_i;
   logic [32*NUM_CH-1:0]  size_i;
   logic [32*NUM_CH-1:0]  realloc_addr_i;
   logic [NUM_CH-1:0]     free_req_i;
   logic [32*NUM_CH-1:0]  free_addr_i;
   logic [NUM_CH-1:0]     alloc_done_o;
   logic [31:0]           alloc_addr_o;
   logic [NUM_CH-1:0]     free_ack_o;
   logic                  free_full_o;
   logic                  busy_o;
   logic                  alc_alloc_req_o;
   logic                  alc_realloc_req_o;
   logic [31:0]           alc_size_o;
   logic [31:0]           alc_realloc_addr_o;
   logic                  alc_free_req_o;
   logic [31:0]           alc_free_addr_o;
   logic                  alc_idle_i;
   logic                  alc_alloc_done_i;
   logic [31:0]           alc_alloc_addr_i;
   logic                  alc_free_done_i;

   modport slave (
      input  stall_i, alloc_req_i, realloc_i, size_i, realloc_addr_i,
             free_req_i, free_addr_i,
             alc_idle_i, alc_alloc_done_i, alc_alloc_addr_i, alc_free_done_i,
      output alloc_done_o, alloc_addr_o, free_ack_o, free_full_o, busy_o,
             alc_alloc_req_o, alc_realloc_req_o, alc_size_o, alc_realloc_addr_o,
             alc_free_req_o, alc_free_addr_o
   );

   modport master (
      output stall_i, alloc_req_i, realloc_i, size_i, realloc_addr_i,
             free_req_i, free_addr_i,
             alc_idle_i, alc_alloc_done_i, alc_alloc_addr_i, alc_free_done_i,
      input  alloc_done_o, alloc_addr_o, free_ack_o, free_full_o, busy_o,
             alc_alloc_req_o, alc_realloc_req_o, alc_size_o, alc_realloc_addr_o,
             alc_free_req_o, alc_free_addr_o
   );
endinterface

// File: rtl/dmm_multi_port_manager.sv
// dmm_multi_port_manager
//   Multi-client front end for the hardware dynamic memory allocator.
//   Round-robin arbitrates allocate/reallocate requests from NUM_CH cores,
//   queues frees in a FREE_DEPTH-entry FIFO, issues one operation at a time
//   to the allocator and routes each result back to its owning channel.
//
//   Ports
//     clk  : clock
//     rst  : asynchronous, active-low reset
//     bus  : dmm_multi_port_manager_if.slave (core request ports, allocator
//            API port, stall_i, status outputs)
//
//   Build option
//     DMM_FREE_PRIORITY_EN : when defined, queued frees always drain before
//                            any allocate; otherwise alloc and free alternate
//                            whenever both are pending.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   IDLE        | no operation in flight; picks next alloc or free
//   ALLOC_ISSUE | one-cycle alloc/realloc pulse to the allocator
//   ALLOC_WAIT  | waiting for alc_alloc_done_i
//   FREE_ISSUE  | one-cycle free pulse (head already popped)
//   FREE_WAIT   | waiting for alc_free_done_i
module dmm_multi_port_manager #(
   parameter int NUM_CH     = 2,
   parameter int FREE_DEPTH = 8
) (
   input logic                     clk,
   input logic                     rst,
   dmm_multi_port_manager_if.slave bus
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW  = $clog2(FREE_DEPTH);
   localparam int CW  = AW + 1;

   typedef enum logic [2:0] {
      IDLE, ALLOC_ISSUE, ALLOC_WAIT, FREE_ISSUE, FREE_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [CHW-1:0]    rr_alloc_q, rr_free_q, owner_q;
   logic [NUM_CH-1:0] alloc_done_q, free_ack_q;
   logic [31:0]       alloc_addr_q, size_q, realloc_addr_q, free_addr_q;
   logic              realloc_q;
   logic [31:0]       fifo_mem [FREE_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;

   logic [NUM_CH-1:0] free_cand, alloc_cand;
   logic [CHW:0]      free_pick, alloc_pick;
   logic              free_hit, alloc_hit, fifo_ne, push, pop;
   logic [CHW-1:0]    free_idx, alloc_idx;
   logic [31:0]       free_gnt_addr, gnt_size, gnt_raddr;
   logic              gnt_realloc, zero_size, take_alloc, take_free;

   // Returns {hit, index}: first set bit of cand searched from ptr upward.
   function automatic logic [CHW:0] rr_pick(input logic [NUM_CH-1:0] cand,
                                            input logic [CHW-1:0]    ptr);
      logic [CHW:0] res;
      res = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         int idx;
         idx = (int'(ptr) + i) % NUM_CH;
         if (cand[idx]) res = {1'b1, CHW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [CHW-1:0] rr_next(input logic [CHW-1:0] idx);
      return CHW'((int'(idx) + 1) % NUM_CH);
   endfunction

   // Channels pulsed this cycle are masked so a still-high level request is
   // not granted twice.
   always_comb begin
      free_cand  = (count_q < CW'(FREE_DEPTH)) ? (bus.free_req_i & ~free_ack_q) : '0;
      alloc_cand = bus.alloc_req_i & ~alloc_done_q;
      free_pick  = rr_pick(free_cand, rr_free_q);
      alloc_pick = rr_pick(alloc_cand, rr_alloc_q);
      free_hit   = free_pick[CHW];
      free_idx   = free_pick[CHW-1:0];
      alloc_hit  = alloc_pick[CHW];
      alloc_idx  = alloc_pick[CHW-1:0];
      free_gnt_addr = bus.free_addr_i[int'(free_idx)*32 +: 32];
      gnt_size      = bus.size_i[int'(alloc_idx)*32 +: 32];
      gnt_raddr     = bus.realloc_addr_i[int'(alloc_idx)*32 +: 32];
      gnt_realloc   = bus.realloc_i[alloc_idx];
      zero_size     = !gnt_realloc && (gnt_size == 32'd0);
      fifo_ne       = (count_q != '0);
      push          = free_hit && (free_gnt_addr != 32'd0);
   end

`ifndef DMM_FREE_PRIORITY_EN
   logic pref_alloc_q;
   logic both_pend;
`endif

   always_comb begin
      state_d    = state_q;
      take_alloc = 1'b0;
      take_free  = 1'b0;
`ifndef DMM_FREE_PRIORITY_EN
      both_pend  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.alc_idle_i && !bus.stall_i) begin
`ifdef DMM_FREE_PRIORITY_EN
               if (fifo_ne)        take_free  = 1'b1;
               else if (alloc_hit) take_alloc = 1'b1;
`else
               both_pend = fifo_ne && alloc_hit;
               if (both_pend) begin
                  take_alloc = pref_alloc_q;
                  take_free  = !pref_alloc_q;
               end else begin
                  take_free  = fifo_ne;
                  take_alloc = alloc_hit;
               end
`endif
               // A zero-size plain allocate completes locally and stays in IDLE.
               if (take_free)                      state_d = FREE_ISSUE;
               else if (take_alloc && !zero_size) state_d = ALLOC_ISSUE;
            end
         end
         ALLOC_ISSUE: state_d = ALLOC_WAIT;
         ALLOC_WAIT:  if (bus.alc_alloc_done_i) state_d = IDLE;
         FREE_ISSUE:  state_d = FREE_WAIT;
         FREE_WAIT:   if (bus.alc_free_done_i) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   assign pop = take_free;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

`ifndef DMM_FREE_PRIORITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           pref_alloc_q <= 1'b0;
      else if (both_pend) pref_alloc_q <= take_free;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_alloc_q     <= '0;
         owner_q        <= '0;
         size_q         <= '0;
         realloc_addr_q <= '0;
         realloc_q      <= 1'b0;
         alloc_done_q   <= '0;
         alloc_addr_q   <= '0;
         free_addr_q    <= '0;
      end else begin
         alloc_done_q <= '0;
         alloc_addr_q <= '0;
         if (take_alloc) begin
            rr_alloc_q <= rr_next(alloc_idx);
            owner_q    <= alloc_idx;
            if (zero_size) begin
               alloc_done_q[alloc_idx] <= 1'b1;
            end else begin
               size_q         <= gnt_size;
               realloc_addr_q <= gnt_raddr;
               // Reallocating a null block is just an allocate.
               realloc_q      <= gnt_realloc && (gnt_raddr != 32'd0);
            end
         end
         if (state_q == ALLOC_WAIT && bus.alc_alloc_done_i) begin
            alloc_done_q[owner_q] <= 1'b1;
            alloc_addr_q          <= bus.alc_alloc_addr_i;
         end
         if (take_free) free_addr_q <= fifo_mem[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_free_q  <= '0;
         free_ack_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         free_ack_q <= '0;
         if (free_hit) begin
            free_ack_q[free_idx] <= 1'b1;
            rr_free_q            <= rr_next(free_idx);
         end
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= free_gnt_addr;
   end

   assign bus.alloc_done_o       = alloc_done_q;
   assign bus.alloc_addr_o       = alloc_addr_q;
   assign bus.free_ack_o         = free_ack_q;
   assign bus.free_full_o        = (count_q == CW'(FREE_DEPTH));
   assign bus.busy_o             = (state_q != IDLE) || fifo_ne;
   assign bus.alc_alloc_req_o    = (state_q == ALLOC_ISSUE) && !realloc_q;
   assign bus.alc_realloc_req_o  = (state_q == ALLOC_ISSUE) && realloc_q;
   assign bus.alc_size_o         = size_q;
   assign bus.alc_realloc_addr_o = realloc_addr_q;
   assign bus.alc_free_req_o     = (state_q == FREE_ISSUE);
   assign bus.alc_free_addr_o    = free_addr_q;
endmodule
